alarm_ctrl: RTL and testbench

//  Alarm controller for the 24h clock. Holds a BCD alarm time (HH:MM) edited with debounced

---
 rtl/alarm_ctrl_if.sv | 51 +++++
 rtl/alarm_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_alarm_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_ctrl_if.sv
// ============================================================================
// Module      : alarm_ctrl_if
// Description : Button, time-of-day and alarm display signals of alarm_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alarm_ctrl_if;
    // Timebase and debounced button pulses
    logic       en1hz;
    logic       sig2hz;
    logic       almode;
    logic       select;
    logic       adjust;
    logic       snooze;
    // Running time of day, BCD
    logic [1:0] hourh;
    logic [3:0] hourl;
    logic [2:0] minh;
    logic [3:0] minl;
    logic [2:0] sech;
    logic [3:0] secl;
    // Alarm time, display enables and annunciators
    logic [1:0] ahourh;
    logic [3:0] ahourl;
    logic [2:0] aminh;
    logic [3:0] aminl;
    logic       ashow;
    logic       ahouron;
    logic       aminon;
    logic       armed;
    logic       ring;
    logic       buzz;
    logic [1:0] snzcnt;

    modport master (
        output en1hz, sig2hz, almode, select, adjust, snooze,
        output hourh, hourl, minh, minl, sech, secl,
        input  ahourh, ahourl, aminh, aminl, ashow, ahouron, aminon,
        input  armed, ring, buzz, snzcnt
    );

    modport slave (
        input  en1hz, sig2hz, almode, select, adjust, snooze,
        input  hourh, hourl, minh, minl, sech, secl,
        output ahourh, ahourl, aminh, aminl, ashow, ahouron, aminon,
        output armed, ring, buzz, snzcnt
    );
endinterface

`default_nettype wire

// File: rtl/alarm_ctrl.sv
// ============================================================================
// Module      : alarm_ctrl
// Description : 24h alarm controller: BCD alarm edit, arm, match, ring/snooze.
//               Optional snooze support enabled by macro ALARM_SNOOZE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alarm_ctrl #(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int SNOOZE_MAX = 3
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    alarm_ctrl_if.slave bus_if
);

    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_set_hour = 3'd1;
    localparam logic [2:0] c_st_set_min  = 3'd2;
    localparam logic [2:0] c_st_ringing  = 3'd3;
    localparam logic [7:0] c_ring_last   = 8'(RING_SEC - 1);

    logic [2:0] state_q,    state_d;
    logic [1:0] ahourh_q,   ahourh_d;
    logic [3:0] ahourl_q,   ahourl_d;
    logic [2:0] aminh_q,    aminh_d;
    logic [3:0] aminl_q,    aminl_d;
    logic       armed_q,    armed_d;
    logic       match_dly_q;
    logic [7:0] ring_cnt_q, ring_cnt_d;
    logic       w_match;
    logic       w_trigger;
    logic       w_dismiss;
    logic       w_ashow;
    logic       w_ahouron;
    logic       w_aminon;
    logic       w_ring;

`ifdef ALARM_SNOOZE_EN
    localparam logic [2:0] c_st_snoozed = 3'd4;
    localparam logic [9:0] c_snz_load   = 10'(SNOOZE_SEC);
    localparam logic [2:0] c_snz_max    = 3'(SNOOZE_MAX);

    logic [9:0] snz_tmr_q, snz_tmr_d;
    logic [1:0] snzcnt_q,  snzcnt_d;
`else
    logic w_unused_snooze;
    assign w_unused_snooze = ^{bus_if.snooze, 10'(SNOOZE_SEC), 2'(SNOOZE_MAX)};
`endif

    // Seconds must be 00 so the alarm fires once, at the top of the minute.
    assign w_match = armed_q
                   & (bus_if.hourh == ahourh_q) & (bus_if.hourl == ahourl_q)
                   & (bus_if.minh  == aminh_q)  & (bus_if.minl  == aminl_q)
                   & (bus_if.sech  == 3'd0)     & (bus_if.secl  == 4'd0);
    assign w_trigger = w_match & ~match_dly_q;
    assign w_dismiss = bus_if.almode | bus_if.adjust;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= c_st_idle;
            ahourh_q    <= 2'd0;
            ahourl_q    <= 4'd6;
            aminh_q     <= 3'd0;
            aminl_q     <= 4'd0;
            armed_q     <= 1'b0;
            match_dly_q <= 1'b0;
            ring_cnt_q  <= 8'd0;
`ifdef ALARM_SNOOZE_EN
            snz_tmr_q   <= 10'd0;
            snzcnt_q    <= 2'd0;
`endif
        end else begin
            state_q     <= state_d;
            ahourh_q    <= ahourh_d;
            ahourl_q    <= ahourl_d;
            aminh_q     <= aminh_d;
            aminl_q     <= aminl_d;
            armed_q     <= armed_d;
            match_dly_q <= w_match;
            ring_cnt_q  <= ring_cnt_d;
`ifdef ALARM_SNOOZE_EN
            snz_tmr_q   <= snz_tmr_d;
            snzcnt_q    <= snzcnt_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        ahourh_d   = ahourh_q;
        ahourl_d   = ahourl_q;
        aminh_d    = aminh_q;
        aminl_d    = aminl_q;
        armed_d    = armed_q;
        ring_cnt_d = ring_cnt_q;
`ifdef ALARM_SNOOZE_EN
        snz_tmr_d  = snz_tmr_q;
        snzcnt_d   = snzcnt_q;
`endif
        case (state_q)
            c_st_idle: begin
                if (bus_if.almode) begin
                    state_d = c_st_set_hour;
                end else if (w_trigger) begin
                    state_d    = c_st_ringing;
                    ring_cnt_d = 8'd0;
`ifdef ALARM_SNOOZE_EN
                    snzcnt_d   = 2'd0;
`endif
                end else if (bus_if.adjust) begin
                    armed_d = ~armed_q;
                end
            end
            c_st_set_hour: begin
                if (bus_if.almode) begin
                    state_d = c_st_idle;
                end else if (bus_if.select) begin
                    state_d = c_st_set_min;
                end else if (bus_if.adjust) begin
                    if (ahourh_q == 2'd2 && ahourl_q == 4'd3) begin
                        ahourh_d = 2'd0;
                        ahourl_d = 4'd0;
                    end else if (ahourl_q == 4'd9) begin
                        ahourh_d = ahourh_q + 2'd1;
                        ahourl_d = 4'd0;
                    end else begin
                        ahourl_d = ahourl_q + 4'd1;
                    end
                end
            end
            c_st_set_min: begin
                if (bus_if.almode) begin
                    state_d = c_st_idle;
                end else if (bus_if.select) begin
                    state_d = c_st_set_hour;
                end else if (bus_if.adjust) begin
                    // Minute wraps 59 -> 00 on its own; the hour is left alone.
                    if (aminl_q == 4'd9) begin
                        aminl_d = 4'd0;
                        aminh_d = (aminh_q == 3'd5) ? 3'd0 : aminh_q + 3'd1;
                    end else begin
                        aminl_d = aminl_q + 4'd1;
                    end
                end
            end
            c_st_ringing: begin
                if (w_dismiss) begin
                    state_d = c_st_idle;
                end
`ifdef ALARM_SNOOZE_EN
                else if (bus_if.snooze && ({1'b0, snzcnt_q} < c_snz_max)) begin
                    state_d   = c_st_snoozed;
                    snz_tmr_d = c_snz_load;
                    snzcnt_d  = snzcnt_q + 2'd1;
                end
`endif
                else if (bus_if.en1hz) begin
                    if (ring_cnt_q == c_ring_last) begin
                        state_d = c_st_idle;
                    end else begin
                        ring_cnt_d = ring_cnt_q + 8'd1;
                    end
                end
            end
`ifdef ALARM_SNOOZE_EN
            c_st_snoozed: begin
                if (w_dismiss) begin
                    state_d = c_st_idle;
                end else if (bus_if.en1hz) begin
                    if (snz_tmr_q == 10'd1) begin
                        state_d    = c_st_ringing;
                        ring_cnt_d = 8'd0;
                        snz_tmr_d  = 10'd0;
                    end else begin
                        snz_tmr_d = snz_tmr_q - 10'd1;
                    end
                end
            end
`endif
            default: state_d = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // State-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_ashow   = 1'b0;
        w_ahouron = 1'b1;
        w_aminon  = 1'b1;
        w_ring    = 1'b0;
        case (state_q)
            c_st_set_hour: begin
                w_ashow   = 1'b1;
                w_ahouron = bus_if.sig2hz;
            end
            c_st_set_min: begin
                w_ashow  = 1'b1;
                w_aminon = bus_if.sig2hz;
            end
            c_st_ringing: w_ring = 1'b1;
            default: ;
        endcase
    end

    assign bus_if.ahourh  = ahourh_q;
    assign bus_if.ahourl  = ahourl_q;
    assign bus_if.aminh   = aminh_q;
    assign bus_if.aminl   = aminl_q;
    assign bus_if.armed   = armed_q;
    assign bus_if.ashow   = w_ashow;
    assign bus_if.ahouron = w_ahouron;
    assign bus_if.aminon  = w_aminon;
    assign bus_if.ring    = w_ring;
    assign bus_if.buzz    = w_ring & bus_if.sig2hz;
`ifdef ALARM_SNOOZE_EN
    assign bus_if.snzcnt  = snzcnt_q;
`else
    assign bus_if.snzcnt  = 2'b00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alarm_ctrl.sv
// ============================================================================
// Module      : tb_alarm_ctrl
// Description : Directed and random stimulus against a time-of-day level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alarm_ctrl;

    localparam int RING_SEC   = 60;
    localparam int SNOOZE_SEC = 300;
    localparam int SNOOZE_MAX = 3;
`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ_EN = 1'b1;
`else
    localparam bit SNZ_EN = 1'b0;
`endif

    typedef enum int {M_IDLE, M_SETH, M_SETM, M_RING, M_SNZ} mode_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alarm_ctrl_if bus ();

    alarm_ctrl #(
        .RING_SEC   (RING_SEC),
        .SNOOZE_SEC (SNOOZE_SEC),
        .SNOOZE_MAX (SNOOZE_MAX)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus)
    );

    int    errors = 0;
    int    checks = 0;
    int    cyc    = 0;
    // Model: alarm and clock held as plain hours/minutes/seconds
    mode_t mode;
    int    al_h, al_m, ring_sec, snooze_left, snz;
    bit    armed, prev_match;
    int    t_h = 12, t_m = 0, t_s = 0;

    task automatic chk(input string tag, input string what,
                       input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s observed=%0h expected=%0h", tag, what, obs, exp);
        end
    endtask

    function automatic logic [15:0] bcd(input int v);
        return 16'((v / 10) * 16 + (v % 10));
    endfunction

    task automatic model_reset();
        mode = M_IDLE; al_h = 6; al_m = 0; armed = 0; prev_match = 0;
        ring_sec = 0; snooze_left = 0; snz = 0;
    endtask

    task automatic drive_time();
        bus.hourh = 2'(t_h / 10); bus.hourl = 4'(t_h % 10);
        bus.minh  = 3'(t_m / 10); bus.minl  = 4'(t_m % 10);
        bus.sech  = 3'(t_s / 10); bus.secl  = 4'(t_s % 10);
    endtask

    task automatic set_time_secs(input int tot);
        tot = ((tot % 86400) + 86400) % 86400;
        t_h = tot / 3600; t_m = (tot / 60) % 60; t_s = tot % 60;
        drive_time();
    endtask

    task automatic model_step();
        bit m, trig;
        m = armed && (t_h == al_h) && (t_m == al_m) && (t_s == 0);
        trig = m && !prev_match;
        prev_match = m;
        case (mode)
            M_IDLE:
                if (bus.almode) mode = M_SETH;
                else if (trig) begin mode = M_RING; ring_sec = 0; snz = 0; end
                else if (bus.adjust) armed = !armed;
            M_SETH:
                if (bus.almode) mode = M_IDLE;
                else if (bus.select) mode = M_SETM;
                else if (bus.adjust) al_h = (al_h + 1) % 24;
            M_SETM:
                if (bus.almode) mode = M_IDLE;
                else if (bus.select) mode = M_SETH;
                else if (bus.adjust) al_m = (al_m + 1) % 60;
            M_RING:
                if (bus.almode || bus.adjust) mode = M_IDLE;
                else if (SNZ_EN && bus.snooze && snz < SNOOZE_MAX) begin
                    mode = M_SNZ; snooze_left = SNOOZE_SEC; snz++;
                end else if (bus.en1hz) begin
                    ring_sec++;
                    if (ring_sec >= RING_SEC) mode = M_IDLE;
                end
            M_SNZ:
                if (bus.almode || bus.adjust) mode = M_IDLE;
                else if (bus.en1hz) begin
                    snooze_left--;
                    if (snooze_left == 0) begin mode = M_RING; ring_sec = 0; end
                end
            default: mode = M_IDLE;
        endcase
    endtask

    task automatic check_all(input string tag);
        bit r;
        r = (mode == M_RING);
        chk(tag, "ahour",   16'({bus.ahourh, bus.ahourl}), bcd(al_h));
        chk(tag, "amin",    16'({bus.aminh, bus.aminl}),   bcd(al_m));
        chk(tag, "ashow",   16'(bus.ashow),   16'(mode == M_SETH || mode == M_SETM));
        chk(tag, "ahouron", 16'(bus.ahouron), 16'((mode == M_SETH) ? bus.sig2hz : 1'b1));
        chk(tag, "aminon",  16'(bus.aminon),  16'((mode == M_SETM) ? bus.sig2hz : 1'b1));
        chk(tag, "armed",   16'(bus.armed),   16'(armed));
        chk(tag, "ring",    16'(bus.ring),    16'(r));
        chk(tag, "buzz",    16'(bus.buzz),    16'(r & bus.sig2hz));
        chk(tag, "snzcnt",  16'(bus.snzcnt),  16'(SNZ_EN ? snz : 0));
    endtask

    // One clock: model consumes the driven inputs, then all outputs are compared.
    task automatic step(input string tag, input bit a_mode, input bit a_sel,
                        input bit a_adj, input bit a_snz, input bit a_sec);
        bus.almode = a_mode; bus.select = a_sel; bus.adjust = a_adj;
        bus.snooze = a_snz;  bus.en1hz  = a_sec;
        model_step();
        @(posedge clk);
        #1;
        if (bus.en1hz) set_time_secs(t_h * 3600 + t_m * 60 + t_s + 1);
        bus.almode = 0; bus.select = 0; bus.adjust = 0; bus.snooze = 0; bus.en1hz = 0;
        cyc++;
        bus.sig2hz = ((cyc / 8) % 2) == 1;
        #1;
        check_all(tag);
    endtask

    task automatic ring_up(input string tag);
        set_time_secs(al_h * 3600 + al_m * 60 - 1);
        step(tag, 0, 0, 0, 0, 0);
        step(tag, 0, 0, 0, 0, 1);
        step(tag, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bus.almode = 0; bus.select = 0; bus.adjust = 0; bus.snooze = 0;
        bus.en1hz = 0; bus.sig2hz = 0;
        drive_time();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset", "ahour_const", 16'({bus.ahourh, bus.ahourl}), 16'h06);
        rst_n = 1'b1;
        #1;

        // 1: enter hour edit, advance hour 06 -> 13
        step("t1", 1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) step("t1", 0, 0, 1, 0, 0);
        chk("t1", "ahour_const", 16'({bus.ahourh, bus.ahourl}), 16'h13);
        chk("t1", "ashow_const", 16'(bus.ashow), 16'h1);
        for (int i = 0; i < 16; i++) step("t1_blink", 0, 0, 0, 0, 0);

        // 2: minute wrap without carry, hour wrap 23 -> 00
        step("t2", 0, 1, 0, 0, 0);
        for (int i = 0; i < 59; i++) step("t2", 0, 0, 1, 0, 0);
        chk("t2", "amin59", 16'({bus.aminh, bus.aminl}), 16'h59);
        step("t2", 0, 0, 1, 0, 0);
        chk("t2", "amin00", 16'({bus.aminh, bus.aminl}), 16'h00);
        chk("t2", "ahour_keep", 16'({bus.ahourh, bus.ahourl}), 16'h13);
        step("t2", 0, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) step("t2", 0, 0, 1, 0, 0);
        chk("t2", "ahour23", 16'({bus.ahourh, bus.ahourl}), 16'h23);
        step("t2", 0, 0, 1, 0, 0);
        chk("t2", "ahour00", 16'({bus.ahourh, bus.ahourl}), 16'h00);

        // 3: alarm 07:30, arm, trigger, ring for RING_SEC seconds
        for (int i = 0; i < 7; i++) step("t3", 0, 0, 1, 0, 0);
        step("t3", 0, 1, 0, 0, 0);
        for (int i = 0; i < 30; i++) step("t3", 0, 0, 1, 0, 0);
        step("t3", 1, 0, 0, 0, 0);
        step("t3", 0, 0, 1, 0, 0);
        chk("t3", "armed_const", 16'(bus.armed), 16'h1);
        set_time_secs(7 * 3600 + 29 * 60 + 59);
        step("t3", 0, 0, 0, 0, 0);
        step("t3", 0, 0, 0, 0, 1);
        chk("t3", "ring_pre", 16'(bus.ring), 16'h0);
        step("t3", 0, 0, 0, 0, 0);
        chk("t3", "ring_on", 16'(bus.ring), 16'h1);
        for (int i = 0; i < RING_SEC - 1; i++) begin
            step("t3_ring", 0, 0, 0, 0, 1);
            step("t3_ring", 0, 0, 0, 0, 0);
        end
        chk("t3", "ring_held", 16'(bus.ring), 16'h1);
        step("t3", 0, 0, 0, 0, 1);
        chk("t3", "ring_timeout", 16'(bus.ring), 16'h0);
        chk("t3", "armed_kept", 16'(bus.armed), 16'h1);

        // 4: snooze cycles, the one past SNOOZE_MAX is ignored
        ring_up("t4");
        for (int k = 0; k <= SNOOZE_MAX; k++) begin
            step("t4_snz", 0, 0, 0, 1, 0);
            for (int s = 0; s < SNOOZE_SEC; s++) begin
                step("t4_wait", 0, 0, 0, 0, 1);
                step("t4_wait", 0, 0, 0, 0, 0);
            end
        end

        // 5: dismiss beats snooze; disarmed alarm stays silent
        ring_up("t5");
        chk("t5", "ring_on", 16'(bus.ring), 16'h1);
        step("t5", 1, 0, 0, 1, 0);
        chk("t5", "ring_dismiss", 16'(bus.ring), 16'h0);
        step("t5", 0, 0, 1, 0, 0);
        chk("t5", "disarmed", 16'(bus.armed), 16'h0);
        ring_up("t5_noring");
        chk("t5", "no_trigger", 16'(bus.ring), 16'h0);

        // 6: asynchronous reset in the middle of a ringing cycle
        step("t6", 0, 0, 1, 0, 0);
        ring_up("t6");
        while (bus.sig2hz !== 1'b1) step("t6", 0, 0, 0, 0, 0);
        chk("t6", "buzz_on", 16'(bus.buzz), 16'h1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t6", "ring_async", 16'(bus.ring), 16'h0);
        chk("t6", "buzz_async", 16'(bus.buzz), 16'h0);
        chk("t6", "ahour_async", 16'({bus.ahourh, bus.ahourl}), 16'h06);
        chk("t6", "armed_async", 16'(bus.armed), 16'h0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;

        // Random traffic with frequent jumps to just before the alarm minute
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 47) == 0) set_time_secs(al_h * 3600 + al_m * 60 - 2);
            step("rand",
                 $urandom_range(0, 23) == 0,
                 $urandom_range(0, 7)  == 0,
                 $urandom_range(0, 9)  == 0,
                 $urandom_range(0, 5)  == 0,
                 $urandom_range(0, 1)  == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
